mvu_act_replay_buf: RTL and testbench
=====================================

MVU_ACT_REPLAY_BUF -- requirements
Module: mvu_act_replay_buf

Interface
REQ-001 Parameter SF, default 4: synapse fold, the number of input words per activation vector (SF >= 1).
REQ-002 Parameter NF, default 2: neuron fold, the number of times each stored vector is replayed to the PE array (NF >= 1).
REQ-003 Parameter TI, default 8: activation word width in bits, TSrcI*SIMD.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 Port in_v, input, 1 bit: upstream activation word valid.
REQ-007 Port in_act, input, TI bits: upstream activation word.
REQ-008 Port in_rdy, output, 1 bit: block accepts in_act this cycle.
REQ-009 Port out_rdy, input, 1 bit: downstream PE array can advance; 0 = stall.
REQ-010 Port out_v, output, 1 bit: out_act is valid.
REQ-011 Port out_act, output, TI bits: activation word to the PE array.
REQ-012 Port sf_clr, output, 1 bit: marks the last word of an SF fold; qualified by out_v.

Function
REQ-013 The block SHALL hold an SF-entry x TI-bit storage array, indexed by sf_cnt (0..SF-1), plus nf_cnt (0..NF-1) and a two-state FSM: FILL and REPLAY.
REQ-014 in_rdy SHALL be combinational: in_rdy = (state==FILL) && out_rdy.
REQ-015 out_v, out_act and sf_clr SHALL be registered: a word accepted or read in cycle N appears at the outputs in cycle N+1.
REQ-016 When out_rdy=0, the block SHALL hold all state, counters and outputs unchanged, and SHALL not write the storage array.
REQ-017 In FILL with in_v && in_rdy, the block SHALL:
- write mem[sf_cnt] <= in_act
- set out_act <= in_act and out_v <= 1
- set sf_clr <= (sf_cnt==SF-1)
- increment sf_cnt
REQ-018 In FILL with out_rdy=1 and in_v=0, the block SHALL set out_v <= 0 and sf_clr <= 0, and SHALL leave counters unchanged.
REQ-019 On the FILL word with sf_cnt==SF-1, the block SHALL wrap sf_cnt to 0 and:
- if NF==1: stay in FILL with nf_cnt=0
- otherwise: set nf_cnt <= 1 and go to REPLAY
REQ-020 In REPLAY with out_rdy=1, the block SHALL set out_act <= mem[sf_cnt], out_v <= 1 and sf_clr <= (sf_cnt==SF-1), and SHALL increment sf_cnt; one word is issued per cycle with no bubbles.
REQ-021 On the REPLAY word with sf_cnt==SF-1, the block SHALL wrap sf_cnt to 0 and:
- if nf_cnt==NF-1: set nf_cnt <= 0 and go to FILL
- otherwise: increment nf_cnt
REQ-022 Each accepted vector SHALL produce exactly NF*SF output words, in index order 0..SF-1 for every pass, with sf_clr high on exactly NF of them.
REQ-023 For SF==1, sf_clr SHALL be high on every valid output word.
REQ-024 Counter widths SHALL be max(1,$clog2(SF)) and max(1,$clog2(NF)) bits; counters SHALL never take values >= SF or >= NF.
REQ-025 A new vector SHALL NOT be accepted until the last replay word of the previous vector has been issued; the cycle after that word, in_rdy may assert (FILL state).

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force:
- out_v=0, sf_clr=0, out_act=0
- sf_cnt=0, nf_cnt=0, state=FILL
REQ-027 The storage array SHALL NOT be reset.
REQ-028 Reset asserted mid-FILL or mid-REPLAY SHALL discard the partial vector; after release, the first accepted word is treated as index 0 of a new vector.

Verification
REQ-029 With SF=4, NF=3, TI=8 and out_rdy=1, stream A0..A3 = 0x11,0x22,0x33,0x44 back-to-back. Required response:
- out_act = 11,22,33,44 repeated 3 times on 12 consecutive cycles starting one cycle after A0
- sf_clr high on every 0x44
- in_rdy low from the cycle after A3 until the last 0x44 is issued
REQ-030 Same configuration, deassert out_rdy for 2 cycles during the second pass. Required response:
- outputs frozen during the stall
- no word lost or duplicated; total 12 words
REQ-031 Drop in_v for 1 cycle between A1 and A2 in FILL. Required response:
- one out_v=0 bubble
- replay passes remain gapless with unchanged order
REQ-032 With SF=1 and NF=1, stream 5 words. Required response:
- each word echoed one cycle later with sf_clr=1
- in_rdy continuously high
REQ-033 Assert rst_n=0 during the second replay pass, then release and send B0..B3. Required response:
- out_v=0 immediately on reset
- afterwards exactly B0..B3 x3 is output, with no residue of the A vector

Source files
------------

// File: rtl/mvu_act_replay_buf.sv
// Activation replay buffer for an MVU PE array.
// Captures one SF-word activation vector while echoing it downstream, then
// replays the stored vector NF-1 more times so that each neuron fold sees
// the same input vector. A single out_rdy stall freezes the whole block.
module mvu_act_replay_buf #(
    parameter int SF = 4,
    parameter int NF = 2,
    parameter int TI = 8
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          in_v,
    input  logic [TI-1:0] in_act,
    output logic          in_rdy,
    input  logic          out_rdy,
    output logic          out_v,
    output logic [TI-1:0] out_act,
    output logic          sf_clr
);

    localparam int SW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SW-1:0] SF_LAST = SW'(SF - 1);
    localparam logic [NW-1:0] NF_LAST = NW'(NF - 1);

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sf_cnt_q, sf_cnt_d;
    logic [NW-1:0] nf_cnt_q, nf_cnt_d;
    logic          out_v_q, out_v_d;
    logic [TI-1:0] out_act_q, out_act_d;
    logic          sf_clr_q, sf_clr_d;
    logic          mem_we;
    logic          sf_last;
    logic [TI-1:0] mem_q [SF];

    assign sf_last = (sf_cnt_q == SF_LAST);
    assign in_rdy  = (state_q == FILL) && out_rdy;
    assign out_v   = out_v_q;
    assign out_act = out_act_q;
    assign sf_clr  = sf_clr_q;

    // Next-state, counter and output-register logic; everything holds on stall.
    always_comb begin
        state_d   = state_q;
        sf_cnt_d  = sf_cnt_q;
        nf_cnt_d  = nf_cnt_q;
        out_v_d   = out_v_q;
        out_act_d = out_act_q;
        sf_clr_d  = sf_clr_q;
        mem_we    = 1'b0;
        if (out_rdy) begin
            if (state_q == FILL) begin
                if (in_v) begin
                    mem_we    = 1'b1;
                    out_act_d = in_act;
                    out_v_d   = 1'b1;
                    sf_clr_d  = sf_last;
                    if (sf_last) begin
                        sf_cnt_d = '0;
                        if (NF > 1) begin
                            nf_cnt_d = NW'(1);
                            state_d  = REPLAY;
                        end else begin
                            nf_cnt_d = '0;
                        end
                    end else begin
                        sf_cnt_d = sf_cnt_q + SW'(1);
                    end
                end else begin
                    out_v_d  = 1'b0;
                    sf_clr_d = 1'b0;
                end
            end else begin
                out_act_d = mem_q[sf_cnt_q];
                out_v_d   = 1'b1;
                sf_clr_d  = sf_last;
                if (sf_last) begin
                    sf_cnt_d = '0;
                    if (nf_cnt_q == NF_LAST) begin
                        nf_cnt_d = '0;
                        state_d  = FILL;
                    end else begin
                        nf_cnt_d = nf_cnt_q + NW'(1);
                    end
                end else begin
                    sf_cnt_d = sf_cnt_q + SW'(1);
                end
            end
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            sf_cnt_q  <= '0;
            nf_cnt_q  <= '0;
            out_v_q   <= 1'b0;
            out_act_q <= '0;
            sf_clr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sf_cnt_q  <= sf_cnt_d;
            nf_cnt_q  <= nf_cnt_d;
            out_v_q   <= out_v_d;
            out_act_q <= out_act_d;
            sf_clr_q  <= sf_clr_d;
        end
    end

    // Vector storage; deliberately not reset, contents are rewritten every fill.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[sf_cnt_q] <= in_act;
        end
    end

endmodule

// File: tb/tb_mvu_act_replay_buf.sv
// Bench for mvu_act_replay_buf: two instances (SF=4/NF=3 and SF=1/NF=1)
// checked every cycle against a word-index reference model, plus directed
// scenarios with literal expectations.
module tb_mvu_act_replay_buf;

    localparam int TI  = 8;
    localparam int SFA = 4;
    localparam int NFA = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    in_v;
    logic [1:0]    out_rdy;
    logic [1:0]    in_rdy;
    logic [1:0]    out_v;
    logic [1:0]    sf_clr;
    logic [TI-1:0] in_act  [2];
    logic [TI-1:0] out_act [2];

    mvu_act_replay_buf #(.SF(SFA), .NF(NFA), .TI(TI)) dut_a (
        .rst_n(rst_n), .clk(clk), .in_v(in_v[0]), .in_act(in_act[0]),
        .in_rdy(in_rdy[0]), .out_rdy(out_rdy[0]), .out_v(out_v[0]),
        .out_act(out_act[0]), .sf_clr(sf_clr[0])
    );

    mvu_act_replay_buf #(.SF(1), .NF(1), .TI(TI)) dut_b (
        .rst_n(rst_n), .clk(clk), .in_v(in_v[1]), .in_act(in_act[1]),
        .in_rdy(in_rdy[1]), .out_rdy(out_rdy[1]), .out_v(out_v[1]),
        .out_act(out_act[1]), .sf_clr(sf_clr[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic int sf_of(int k);
        return (k == 0) ? SFA : 1;
    endfunction

    function automatic int nf_of(int k);
        return (k == 0) ? NFA : 1;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", nm, k, cyc, got, exp);
        end
    endtask

    // Reference model: m_idx counts words issued for the current vector
    // (0..SF*NF-1); the first SF of them come from the input, the rest from storage.
    int            m_idx [2];
    logic [TI-1:0] m_vec [2][SFA];
    logic          m_v   [2];
    logic          m_clr [2];
    logic [TI-1:0] m_act [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_idx[k] <= 0;
                m_v[k]   <= 1'b0;
                m_clr[k] <= 1'b0;
                m_act[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (out_rdy[k]) begin
                    int p;
                    int sf;
                    int nf;
                    p  = m_idx[k];
                    sf = sf_of(k);
                    nf = nf_of(k);
                    if (p < sf) begin
                        if (in_v[k]) begin
                            m_vec[k][p] <= in_act[k];
                            m_act[k]    <= in_act[k];
                            m_v[k]      <= 1'b1;
                            m_clr[k]    <= (p == sf - 1);
                            m_idx[k]    <= (p + 1 == sf * nf) ? 0 : p + 1;
                        end else begin
                            m_v[k]   <= 1'b0;
                            m_clr[k] <= 1'b0;
                        end
                    end else begin
                        m_act[k] <= m_vec[k][p % sf];
                        m_v[k]   <= 1'b1;
                        m_clr[k] <= ((p % sf) == sf - 1);
                        m_idx[k] <= (p + 1 == sf * nf) ? 0 : p + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("out_v", k, 32'(out_v[k]), 32'(m_v[k]));
            if (m_v[k] === 1'b1) begin
                chk("out_act", k, 32'(out_act[k]), 32'(m_act[k]));
                chk("sf_clr", k, 32'(sf_clr[k]), 32'(m_clr[k]));
            end
            chk("in_rdy", k, 32'(in_rdy[k]), 32'((m_idx[k] < sf_of(k)) && out_rdy[k]));
        end
    end

    // Capture of newly issued words (an output register only changes on an
    // edge where out_rdy was high).
    logic [1:0]    rdy_edge = 2'b00;
    logic [TI-1:0] cap0 [$];
    logic [TI-1:0] cap1 [$];
    int            capc0 [$];
    int            capc1 [$];
    int            nclr0 = 0;
    int            nclr1 = 0;
    int            rdy_low0 = 0;
    int            rdy_hi1 = 0;

    always @(posedge clk) rdy_edge <= out_rdy;

    always @(negedge clk) begin
        if (rst_n && out_v[0] && rdy_edge[0]) begin
            cap0.push_back(out_act[0]);
            capc0.push_back(cyc);
            if (sf_clr[0]) nclr0++;
        end
        if (rst_n && out_v[1] && rdy_edge[1]) begin
            cap1.push_back(out_act[1]);
            capc1.push_back(cyc);
            if (sf_clr[1]) nclr1++;
        end
        if (!in_rdy[0]) rdy_low0++;
        if (in_rdy[1]) rdy_hi1++;
    end

    task automatic clear_caps();
        cap0.delete();
        cap1.delete();
        capc0.delete();
        capc1.delete();
        nclr0    = 0;
        nclr1    = 0;
        rdy_low0 = 0;
        rdy_hi1  = 0;
    endtask

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(int k, logic [TI-1:0] d);
        int t;
        t         = 0;
        in_v[k]   = 1'b1;
        in_act[k] = d;
        @(negedge clk);
        while (!in_rdy[k] && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("send_rdy", k, 32'(in_rdy[k]), 32'd1);
        @(posedge clk);
        #1;
        in_v[k] = 1'b0;
    endtask

    task automatic check_vec(string nm, logic [TI-1:0] d [4], int span);
        chk({nm, "_count"}, 0, 32'(cap0.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < cap0.size()) chk({nm, "_word"}, i, 32'(cap0[i]), 32'(d[i % 4]));
        end
        chk({nm, "_clr"}, 0, 32'(nclr0), 32'd3);
        if (cap0.size() >= 12) chk({nm, "_span"}, 0, 32'(capc0[11] - capc0[0]), 32'(span));
    endtask

    task automatic rand_run(int k, int nvec);
        bit done;
        done = 1'b0;
        clear_caps();
        fork
            begin
                for (int v = 0; v < nvec; v++) begin
                    for (int w = 0; w < sf_of(k); w++) begin
                        if ($urandom_range(3) == 0) idle(1);
                        send(k, 8'($urandom));
                    end
                end
                idle(60);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_rdy[k] = ($urandom_range(3) != 0);
                end
                out_rdy[k] = 1'b1;
            end
        join
        idle(20);
        if (k == 0) begin
            chk("rand_count", k, 32'(cap0.size()), 32'(nvec * SFA * NFA));
            chk("rand_clr", k, 32'(nclr0), 32'(nvec * NFA));
        end else begin
            chk("rand_count", k, 32'(cap1.size()), 32'(nvec));
            chk("rand_clr", k, 32'(nclr1), 32'(nvec));
        end
    endtask

    logic [TI-1:0] da [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [TI-1:0] db [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic [TI-1:0] dc [4] = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
    logic [TI-1:0] dd [4] = '{8'h01, 8'h80, 8'h7E, 8'hC3};
    logic [TI-1:0] de [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        in_v      = 2'b00;
        out_rdy   = 2'b11;
        in_act[0] = '0;
        in_act[1] = '0;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_v", k, 32'(out_v[k]), 32'd0);
            chk("rst_sf_clr", k, 32'(sf_clr[k]), 32'd0);
            chk("rst_out_act", k, 32'(out_act[k]), 32'd0);
            chk("rst_in_rdy", k, 32'(in_rdy[k]), 32'd1);
        end
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back vector, no stalls.
        clear_caps();
        for (int i = 0; i < 4; i++) send(0, da[i]);
        idle(14);
        check_vec("stream", da, 11);
        chk("stream_rdy_low", 0, 32'(rdy_low0), 32'd8);

        // Two-cycle stall during the first replay pass.
        clear_caps();
        for (int i = 0; i < 4; i++) send(0, dc[i]);
        idle(2);
        out_rdy[0] = 1'b0;
        idle(2);
        out_rdy[0] = 1'b1;
        idle(14);
        check_vec("stall", dc, 13);

        // One-cycle input bubble between A1 and A2.
        clear_caps();
        send(0, dd[0]);
        send(0, dd[1]);
        idle(1);
        send(0, dd[2]);
        send(0, dd[3]);
        idle(14);
        check_vec("bubble", dd, 12);
        if (capc0.size() >= 12) chk("bubble_replay_gapless", 0, 32'(capc0[11] - capc0[4]), 32'd7);

        // Reset during the second replay pass, then a fresh vector.
        for (int i = 0; i < 4; i++) send(0, da[i]);
        idle(5);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_v", 0, 32'(out_v[0]), 32'd0);
        chk("midrst_sf_clr", 0, 32'(sf_clr[0]), 32'd0);
        chk("midrst_out_act", 0, 32'(out_act[0]), 32'd0);
        idle(2);
        rst_n = 1'b1;
        clear_caps();
        for (int i = 0; i < 4; i++) send(0, db[i]);
        idle(14);
        check_vec("post_rst", db, 11);

        // SF=1, NF=1: straight echo.
        clear_caps();
        for (int i = 0; i < 5; i++) send(1, de[i]);
        idle(2);
        chk("sf1_count", 1, 32'(cap1.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap1.size()) chk("sf1_word", i, 32'(cap1[i]), 32'(de[i]));
        end
        chk("sf1_clr", 1, 32'(nclr1), 32'd5);
        if (cap1.size() >= 5) chk("sf1_span", 1, 32'(capc1[4] - capc1[0]), 32'd4);
        chk("sf1_rdy_high", 1, 32'(rdy_hi1), 32'd7);

        // Randomized traffic with random downstream stalls.
        rand_run(0, 6);
        rand_run(1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
